csr_regfile: RTL and testbench

Control/status register file for the LoongArch pipeline; responder to the writeback stage's CSR access and exception/return signalling. It serves masked CSR reads and writes from `csrrd`/`csrwr`/`csrxchg`, and records exception entry state. On `ertn` it restores privilege state, and it exposes the exception entry PC, return PC and a pending-interrupt flag to fetch/decode. It also hosts the constant timer and interrupt-status logic.

---
 rtl/csr_regfile.sv | 187 ++++++++++++++++++
 tb/tb_csr_regfile.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// LoongArch CSR file: masked CSR access, exception entry/return state,
// constant timer and interrupt-pending generation.
module csr_regfile #(
    parameter logic [31:0] COREID = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic        eret_flush,
    input  logic [31:0] wb_pc,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] era_pc,
    output logic        has_int
);
    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_EENTRY = 14'h0C;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_SAVE1  = 14'h31;
    localparam logic [13:0] CSR_SAVE2  = 14'h32;
    localparam logic [13:0] CSR_SAVE3  = 14'h33;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;

    logic [1:0]  plv, pplv;
    logic        ie, da, pie;
    logic [12:0] lie;
    logic [1:0]  is_sw;
    logic [7:0]  is_hw;
    logic        is_timer, is_ipi;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] era, save0, save1, save2, save3, tid, tval;
    logic [25:0] eentry_va;
    logic        tcfg_en, tcfg_periodic;
    logic [29:0] tcfg_initval;

    logic        wr_en;
    logic [31:0] crmd_val, prmd_val, ecfg_val, estat_val, tcfg_val, wr_merged;
    logic [12:0] is_all;
    logic        unused_ok;

    assign unused_ok = &{1'b0, csr_re};
    assign wr_en     = csr_we & ~wb_ex;

    assign crmd_val  = {28'b0, da, ie, plv};
    assign prmd_val  = {29'b0, pie, pplv};
    assign ecfg_val  = {19'b0, lie};
    assign is_all    = {is_ipi, is_timer, 1'b0, is_hw, is_sw};
    assign estat_val = {1'b0, esubcode, ecode, 3'b0, is_all};
    assign tcfg_val  = {tcfg_initval, tcfg_periodic, tcfg_en};

    always_comb begin
        csr_rvalue = '0;
        case (csr_num)
            CSR_CRMD:   csr_rvalue = crmd_val;
            CSR_PRMD:   csr_rvalue = prmd_val;
            CSR_ECFG:   csr_rvalue = ecfg_val;
            CSR_ESTAT:  csr_rvalue = estat_val;
            CSR_ERA:    csr_rvalue = era;
            CSR_EENTRY: csr_rvalue = {eentry_va, 6'b0};
            CSR_SAVE0:  csr_rvalue = save0;
            CSR_SAVE1:  csr_rvalue = save1;
            CSR_SAVE2:  csr_rvalue = save2;
            CSR_SAVE3:  csr_rvalue = save3;
            CSR_TID:    csr_rvalue = tid;
            CSR_TCFG:   csr_rvalue = tcfg_val;
            CSR_TVAL:   csr_rvalue = tval;
            default:    csr_rvalue = '0;
        endcase
    end

    // Merged write value for the addressed CSR; field selection happens at the register.
    assign wr_merged = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            plv  <= '0;
            ie   <= 1'b0;
            da   <= 1'b1;
            pplv <= '0;
            pie  <= 1'b0;
        end else if (wb_ex) begin
            pplv <= plv;
            pie  <= ie;
            plv  <= '0;
            ie   <= 1'b0;
        end else if (eret_flush) begin
            plv <= pplv;
            ie  <= pie;
        end else if (wr_en && csr_num == CSR_CRMD) begin
            plv <= wr_merged[1:0];
            ie  <= wr_merged[2];
            da  <= wr_merged[3];
        end else if (wr_en && csr_num == CSR_PRMD) begin
            pplv <= wr_merged[1:0];
            pie  <= wr_merged[2];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lie       <= '0;
            is_sw     <= '0;
            is_hw     <= '0;
            is_ipi    <= 1'b0;
            ecode     <= '0;
            esubcode  <= '0;
            era       <= '0;
            eentry_va <= '0;
            save0     <= '0;
            save1     <= '0;
            save2     <= '0;
            save3     <= '0;
            tid       <= COREID;
        end else begin
            is_hw  <= hw_int_in;
            is_ipi <= ipi_int_in;
            if (wb_ex) begin
                ecode    <= wb_ecode;
                esubcode <= wb_esubcode;
                era      <= wb_pc;
            end else if (wr_en) begin
                case (csr_num)
                    CSR_ECFG:   lie       <= wr_merged[12:0] & 13'h1BFF;
                    CSR_ESTAT:  is_sw     <= wr_merged[1:0];
                    CSR_ERA:    era       <= wr_merged;
                    CSR_EENTRY: eentry_va <= wr_merged[31:6];
                    CSR_SAVE0:  save0     <= wr_merged;
                    CSR_SAVE1:  save1     <= wr_merged;
                    CSR_SAVE2:  save2     <= wr_merged;
                    CSR_SAVE3:  save3     <= wr_merged;
                    CSR_TID:    tid       <= wr_merged;
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tcfg_en       <= 1'b0;
            tcfg_periodic <= 1'b0;
            tcfg_initval  <= '0;
            tval          <= '1;
            is_timer      <= 1'b0;
        end else begin
            if (wr_en && csr_num == CSR_TCFG) begin
                tcfg_en       <= wr_merged[0];
                tcfg_periodic <= wr_merged[1];
                tcfg_initval  <= wr_merged[31:2];
            end
            // A TCFG write that enables the timer restarts it; otherwise count with current config.
            if (wr_en && csr_num == CSR_TCFG && wr_merged[0]) begin
                tval <= {wr_merged[31:2], 2'b00};
            end else if (tcfg_en && tval != '1) begin
                if (tval == '0 && tcfg_periodic) tval <= {tcfg_initval, 2'b00};
                else                             tval <= tval - 32'd1;
            end
            if (tcfg_en && tval == '0) begin
                is_timer <= 1'b1;
            end else if (wr_en && csr_num == CSR_TICLR && csr_wmask[0] && csr_wvalue[0]) begin
                is_timer <= 1'b0;
            end
        end
    end

    assign ex_entry = {eentry_va, 6'b0};
    assign era_pc   = era;
    assign has_int  = ie & (|(is_all & lie));

endmodule

// File: tb/tb_csr_regfile.sv
// Directed, table-driven bench for csr_regfile: CSR access, exception/ertn,
// timer modes and interrupt pending.
module tb_csr_regfile;
    logic        clk = 1'b0;
    logic        resetn;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        eret_flush;
    logic [31:0] wb_pc;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] era_pc;
    logic        has_int;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [13:0] CRMD = 14'h00, PRMD = 14'h01, ECFG = 14'h04, ESTAT = 14'h05,
                            ERA = 14'h06, EENTRY = 14'h0C, SAVE0 = 14'h30, SAVE1 = 14'h31,
                            SAVE2 = 14'h32, TID = 14'h40, TCFG = 14'h41, TVAL = 14'h42,
                            TICLR = 14'h44;

    csr_regfile #(.COREID(32'h0000_0005)) dut (
        .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .eret_flush(eret_flush), .wb_pc(wb_pc),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .ex_entry(ex_entry),
        .era_pc(era_pc), .has_int(has_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] num;
        logic [31:0] wm;
        logic [31:0] wv;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [13:0] num, input logic [31:0] exp, input string name);
        csr_num = num;
        #1;
        check(name, csr_rvalue, exp);
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] wm, input logic [31:0] wv);
        csr_we = 1'b1;
        csr_num = num;
        csr_wmask = wm;
        csr_wvalue = wv;
        tick();
        csr_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; csr_re = 1'b0; csr_num = '0; csr_we = 1'b0;
        csr_wmask = '0; csr_wvalue = '0; wb_ex = 1'b0; wb_ecode = '0;
        wb_esubcode = '0; eret_flush = 1'b0; wb_pc = '0; hw_int_in = '0;
        ipi_int_in = 1'b0;

        vecs[0]  = '{SAVE1,  32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
        vecs[1]  = '{SAVE1,  32'hFFFF_0000, 32'hDEAD_BEEF, 32'hDEAD_5678};
        vecs[2]  = '{EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFC0};
        vecs[3]  = '{ECFG,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF};
        vecs[4]  = '{ECFG,   32'h0000_0FFF, 32'h0000_0000, 32'h0000_1000};
        vecs[5]  = '{PRMD,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007};
        vecs[6]  = '{CRMD,   32'h0000_0007, 32'h0000_0007, 32'h0000_000F};
        vecs[7]  = '{ESTAT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[8]  = '{ESTAT,  32'h0000_0001, 32'h0000_0000, 32'h0000_0002};
        vecs[9]  = '{14'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{TICLR,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[11] = '{TID,    32'hFFFF_0000, 32'hCAFE_BABE, 32'hCAFE_0005};
        vecs[12] = '{TVAL,   32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[13] = '{ERA,    32'hFFFF_FFFF, 32'h1C00_0000, 32'h1C00_0000};
        vecs[14] = '{TCFG,   32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[15] = '{SAVE2,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

        tick(); tick();
        resetn = 1'b1;
        rd(CRMD, 32'h8, "rst_crmd");
        rd(TID, 32'h5, "rst_tid");
        rd(TVAL, 32'hFFFF_FFFF, "rst_tval");
        check("rst_has_int", 32'(has_int), 32'h0);
        check("rst_ex_entry", ex_entry, 32'h0);
        check("rst_era_pc", era_pc, 32'h0);

        // Same-cycle read returns the pre-write value.
        csr_we = 1'b1; csr_num = SAVE0; csr_wmask = '1; csr_wvalue = 32'h55;
        #1;
        check("no_bypass_old", csr_rvalue, 32'h0);
        tick();
        csr_we = 1'b0;
        rd(SAVE0, 32'h55, "no_bypass_new");

        for (int i = 0; i < 16; i++) begin
            wr(vecs[i].num, vecs[i].wm, vecs[i].wv);
            rd(vecs[i].num, vecs[i].exp, $sformatf("vec%0d", i));
        end
        rd(TVAL, 32'hFFFF_FFFF, "tcfg_disabled_tval");

        wr(ESTAT, '1, '0);
        wr(ECFG, '1, '0);

        // Exception entry from CRMD=0xF.
        wb_ex = 1'b1; wb_ecode = 6'hB; wb_esubcode = 9'h1A3; wb_pc = 32'h1C00_0100;
        tick();
        wb_ex = 1'b0;
        rd(CRMD, 32'h8, "ex_crmd");
        rd(PRMD, 32'h7, "ex_prmd");
        rd(ESTAT, 32'h68CB_0000, "ex_estat");
        check("ex_era_pc", era_pc, 32'h1C00_0100);
        check("ex_entry", ex_entry, 32'hFFFF_FFC0);

        // ertn beats a CRMD write, then a PRMD write.
        eret_flush = 1'b1;
        wr(CRMD, '1, '0);
        rd(CRMD, 32'hF, "eret_crmd");
        wr(PRMD, '1, '0);
        eret_flush = 1'b0;
        rd(PRMD, 32'h7, "eret_prmd_kept");

        // Exception discards same-cycle CSR writes.
        wb_ex = 1'b1;
        wr(CRMD, 32'h7, 32'h7);
        wb_ex = 1'b0;
        rd(CRMD, 32'h8, "coll_crmd");
        rd(PRMD, 32'h7, "coll_prmd");
        wb_ex = 1'b1; wb_pc = 32'h1C00_0200;
        wr(SAVE1, '1, '0);
        wb_ex = 1'b0;
        rd(SAVE1, 32'hDEAD_5678, "coll_save1");
        rd(PRMD, 32'h0, "coll_prmd2");
        check("coll_era_pc", era_pc, 32'h1C00_0200);

        // One-shot timer; TICLR on the TVAL==0 cycle loses to the set.
        wr(CRMD, 32'h4, 32'h4);
        wr(ECFG, '1, 32'h800);
        wr(TCFG, '1, 32'hD);
        for (int k = 12; k >= 0; k--) begin
            rd(TVAL, 32'(k), $sformatf("oneshot_tval%0d", k));
            if (k == 0) begin
                check("is11_before", (csr_rvalue & 32'h0) | 32'(dut.csr_rvalue == 32'h0), 32'h1);
                csr_num = ESTAT;
                #1;
                check("is11_at_zero", (csr_rvalue >> 11) & 32'h1, 32'h0);
                wr(TICLR, 32'h1, 32'h1);
            end else begin
                tick();
            end
        end
        rd(TVAL, 32'hFFFF_FFFF, "oneshot_wrap");
        csr_num = ESTAT;
        #1;
        check("is11_set", (csr_rvalue >> 11) & 32'h1, 32'h1);
        check("timer_has_int", 32'(has_int), 32'h1);
        tick(); tick();
        rd(TVAL, 32'hFFFF_FFFF, "oneshot_hold");
        wr(TICLR, 32'h1, 32'h1);
        csr_num = ESTAT;
        #1;
        check("is11_clr", (csr_rvalue >> 11) & 32'h1, 32'h0);
        check("clr_has_int", 32'(has_int), 32'h0);

        // Periodic timer.
        wr(TCFG, '1, 32'hB);
        for (int i = 0; i < 18; i++) begin
            rd(TVAL, 32'(8 - (i % 9)), $sformatf("periodic_tval%0d", i));
            tick();
        end
        wr(TCFG, '1, '0);

        // Hardware and IPI lines, one cycle of capture latency.
        wr(ECFG, '1, 32'h4);
        hw_int_in = 8'h01;
        #1;
        check("hw_int_latency", 32'(has_int), 32'h0);
        tick();
        check("hw_has_int", 32'(has_int), 32'h1);
        csr_num = ESTAT;
        #1;
        check("hw_estat_is", csr_rvalue & 32'h3FC, 32'h4);
        hw_int_in = 8'h00;
        #1;
        check("hw_hold", 32'(has_int), 32'h1);
        tick();
        check("hw_drop", 32'(has_int), 32'h0);
        wr(ECFG, '1, 32'h1000);
        ipi_int_in = 1'b1;
        tick();
        check("ipi_has_int", 32'(has_int), 32'h1);
        ipi_int_in = 1'b0;

        // Reset mid-count.
        wr(TCFG, '1, 32'hD);
        tick();
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        rd(TVAL, 32'hFFFF_FFFF, "mid_rst_tval");
        rd(TCFG, 32'h0, "mid_rst_tcfg");
        rd(CRMD, 32'h8, "mid_rst_crmd");
        rd(ESTAT, 32'h0, "mid_rst_estat");
        check("mid_rst_has_int", 32'(has_int), 32'h0);
        check("mid_rst_ex_entry", ex_entry, 32'h0);
        check("mid_rst_era_pc", era_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
